l2_refill_unit: RTL and testbench

Line-fill engine between the second-level instruction cache controller and main memory. When the L2 controller signals a miss (`L2_miss_stall` high, line address on `mem_addr`), this block fetches the 512-bit line as four 128-bit memory beats and assembles it. It then drives a one-cycle write strobe and the line data into the L2 data/tag arrays, whose ways the controller has already set to WRITE. Finally it pulses `L2_complete` so the controller re-enters its access state and hits.

---
 rtl/l2_refill_unit_pkg.sv | 22 ++
 rtl/l2_refill_unit_line_buf.sv | 29 ++
 rtl/l2_refill_unit.sv | 130 +++++++++++++
 tb/tb_l2_refill_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_refill_unit_pkg.sv
// Shared definitions for the L2 line-refill engine.
// Line/beat widths, tag write value, access types and FSM state encodings.
package l2_refill_unit_pkg;

    localparam int L2_LINE_W = 512;
    localparam int L2_BEAT_W = 128;

    localparam logic [1:0] L2_TAG_VD_CLEAN = 2'b10;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [2:0] {
        RF_IDLE  = 3'd0,
        RF_REQ   = 3'd1,
        RF_WAIT  = 3'd2,
        RF_WRITE = 3'd3,
        RF_DONE  = 3'd4,
        RF_HOLD  = 3'd5
    } rf_state_t;

endpackage

// File: rtl/l2_refill_unit_line_buf.sv
// l2_line_buf: beat-indexed 4x128 write register with a flat 512-bit output.
// Ports: clk, rst (async active-low), we/idx/wdata beat write, line out.
module l2_line_buf
    import l2_refill_unit_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [1:0]                 idx,
    input  logic [L2_BEAT_W-1:0]       wdata,
    output logic [BEATS*L2_BEAT_W-1:0] line
);

    logic [BEATS-1:0][L2_BEAT_W-1:0] beat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
        end else if (we) begin
            beat_q[idx] <= wdata;
        end
    end

    // Beat k lands in bits [128k+127:128k] of the flat line.
    assign line = beat_q;

endmodule

// File: rtl/l2_refill_unit.sv
// l2_refill_unit: fetches a 512-bit L2 line as four 128-bit memory beats,
// writes it into the L2 arrays and pulses L2_complete.
// Ports: clk, rst (async active-low); L2_miss_stall/mem_addr/mem_rw request;
// mem_req/mem_beat_addr/mem_gnt/mem_rvalid/mem_rdata memory side;
// L2_wr_en/L2_data_wd/L2_tag_vd/L2_complete array side; refill_err sticky.
module l2_refill_unit
    import l2_refill_unit_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 L2_miss_stall,
    input  logic [25:0]          mem_addr,
    input  logic                 mem_rw,
    output logic                 mem_req,
    output logic [27:0]          mem_beat_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [L2_BEAT_W-1:0] mem_rdata,
    output logic                 L2_wr_en,
    output logic [L2_LINE_W-1:0] L2_data_wd,
    output logic [1:0]           L2_tag_vd,
    output logic                 L2_complete,
    output logic                 refill_err
);

    rf_state_t   state;
    rf_state_t   state_nxt;
    logic [25:0] line_addr;
    logic [1:0]  cnt;
    logic        err_q;
    logic        accept;
    logic        take;
    logic        last;

    assign accept = (state == RF_IDLE) && L2_miss_stall;

    // A beat is captured in WAIT, or in REQ when grant and data coincide.
    assign take = mem_rvalid &&
                  ((state == RF_WAIT) || ((state == RF_REQ) && mem_gnt));

    assign last = (cnt == 2'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RF_IDLE;
            line_addr <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                line_addr <= mem_addr;
                cnt       <= '0;
                if (mem_rw != READ) begin
                    err_q <= 1'b1;
                end
            end else if (take) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RF_IDLE: begin
                if (L2_miss_stall) begin
                    state_nxt = (mem_rw == READ) ? RF_REQ : RF_DONE;
                end
            end
            RF_REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        state_nxt = last ? RF_WRITE : RF_REQ;
                    end else begin
                        state_nxt = RF_WAIT;
                    end
                end
            end
            RF_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = last ? RF_WRITE : RF_REQ;
                end
            end
            RF_WRITE: state_nxt = RF_DONE;
            RF_DONE:  state_nxt = RF_HOLD;
            RF_HOLD: begin
                // Stall level is stale until the controller drops it.
                if (!L2_miss_stall) begin
                    state_nxt = RF_IDLE;
                end
            end
            default:  state_nxt = RF_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        L2_wr_en    = 1'b0;
        L2_tag_vd   = 2'b00;
        L2_complete = 1'b0;
        if (state == RF_REQ) begin
            mem_req = 1'b1;
        end
        if (state == RF_WRITE) begin
            L2_wr_en  = 1'b1;
            L2_tag_vd = L2_TAG_VD_CLEAN;
        end
        if (state == RF_DONE) begin
            L2_complete = 1'b1;
        end
    end

    assign mem_beat_addr = {line_addr, cnt};
    assign refill_err    = err_q;

    l2_line_buf #(
        .BEATS (BEATS)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (take),
        .idx   (cnt),
        .wdata (mem_rdata),
        .line  (L2_data_wd)
    );

endmodule

// File: tb/tb_l2_refill_unit.sv
// Directed self-checking bench for l2_refill_unit.
// Drives the L2 request and a scripted memory; checks against hand values.
module tb_l2_refill_unit;
    import l2_refill_unit_pkg::*;

    logic         clk;
    logic         rst;
    logic         L2_miss_stall;
    logic [25:0]  mem_addr;
    logic         mem_rw;
    logic         mem_req;
    logic [27:0]  mem_beat_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
    logic         L2_wr_en;
    logic [511:0] L2_data_wd;
    logic [1:0]   L2_tag_vd;
    logic         L2_complete;
    logic         refill_err;

    int checks;
    int errors;
    int wr_pulses;
    int cmp_pulses;

    l2_refill_unit dut (
        .clk           (clk),
        .rst           (rst),
        .L2_miss_stall (L2_miss_stall),
        .mem_addr      (mem_addr),
        .mem_rw        (mem_rw),
        .mem_req       (mem_req),
        .mem_beat_addr (mem_beat_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .L2_wr_en      (L2_wr_en),
        .L2_data_wd    (L2_data_wd),
        .L2_tag_vd     (L2_tag_vd),
        .L2_complete   (L2_complete),
        .refill_err    (refill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (L2_wr_en === 1'b1) wr_pulses++;
        if (L2_complete === 1'b1) cmp_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One memory beat: optional grant delay, then grant; data either in the
    // grant cycle (same) or after rd idle cycles in WAIT.
    task automatic beat(input string tag, input logic [27:0] exp_addr,
                        input int gd, input int rd, input bit same,
                        input logic [127:0] d);
        chk({tag, "_req"}, 512'(mem_req), 512'(1'b1));
        chk({tag, "_addr"}, 512'(mem_beat_addr), 512'(exp_addr));
        if (gd > 0) begin
            repeat (gd) tick();
            chk({tag, "_req_held"}, 512'(mem_req), 512'(1'b1));
        end
        mem_gnt = 1'b1;
        if (same) begin
            mem_rvalid = 1'b1;
            mem_rdata  = d;
        end
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!same) begin
            chk({tag, "_req_drop"}, 512'(mem_req), 512'(1'b0));
            repeat (rd) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            tick();
            mem_rvalid = 1'b0;
        end
    endtask

    logic [127:0] d0, d1, d2, d3;
    logic [511:0] saved;
    logic         seen;

    initial begin
        checks        = 0;
        errors        = 0;
        wr_pulses     = 0;
        cmp_pulses    = 0;
        rst           = 1'b0;
        L2_miss_stall = 1'b0;
        mem_addr      = '0;
        mem_rw        = READ;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;

        #2;
        chk("rst_req", 512'(mem_req), 512'(1'b0));
        chk("rst_baddr", 512'(mem_beat_addr), 512'(28'h0));
        chk("rst_wr", 512'(L2_wr_en), 512'(1'b0));
        chk("rst_data", L2_data_wd, 512'h0);
        chk("rst_vd", 512'(L2_tag_vd), 512'(2'b00));
        chk("rst_cmp", 512'(L2_complete), 512'(1'b0));
        chk("rst_err", 512'(refill_err), 512'(1'b0));
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Basic refill, line 0x0001234, 1-cycle grant then rvalid.
        d0 = 128'hA0; d1 = 128'hA1; d2 = 128'hA2; d3 = 128'hA3;
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h0001234;
        mem_rw        = READ;
        tick();
        beat("b0", 28'h00048D0, 0, 0, 0, d0);
        beat("b1", 28'h00048D1, 0, 0, 0, d1);
        beat("b2", 28'h00048D2, 0, 0, 0, d2);
        beat("b3", 28'h00048D3, 0, 0, 0, d3);
        chk("basic_wr", 512'(L2_wr_en), 512'(1'b1));
        chk("basic_vd", 512'(L2_tag_vd), 512'(2'b10));
        chk("basic_cmp_early", 512'(L2_complete), 512'(1'b0));
        chk("basic_data", L2_data_wd, {128'hA3, 128'hA2, 128'hA1, 128'hA0});
        tick();
        chk("basic_cmp", 512'(L2_complete), 512'(1'b1));
        chk("basic_wr_off", 512'(L2_wr_en), 512'(1'b0));
        chk("basic_vd_off", 512'(L2_tag_vd), 512'(2'b00));
        L2_miss_stall = 1'b0;
        tick();
        chk("basic_cmp_off", 512'(L2_complete), 512'(1'b0));
        tick();

        // Stalled memory on top line address, beat 2 slow.
        d0 = {4{32'h1111_0000}}; d1 = {4{32'h2222_0001}};
        d2 = {4{32'h3333_0002}}; d3 = {4{32'h4444_0003}};
        wr_pulses     = 0;
        cmp_pulses    = 0;
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h3FFFFFF;
        tick();
        beat("s0", {26'h3FFFFFF, 2'd0}, 0, 0, 0, d0);
        beat("s1", {26'h3FFFFFF, 2'd1}, 0, 0, 0, d1);
        beat("s2", {26'h3FFFFFF, 2'd2}, 5, 3, 0, d2);
        beat("s3", {26'h3FFFFFF, 2'd3}, 0, 0, 0, d3);
        chk("stall_wr", 512'(L2_wr_en), 512'(1'b1));
        for (int i = 0; i < 20 && L2_complete !== 1'b1; i++) tick();
        chk("stall_cmp", 512'(L2_complete), 512'(1'b1));
        chk("stall_data", L2_data_wd, {d3, d2, d1, d0});
        tick();
        // Stray rvalid while holding must not touch the line.
        saved      = L2_data_wd;
        mem_rvalid = 1'b1;
        mem_rdata  = {4{32'hDEAD_BEEF}};
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid", L2_data_wd, saved);
        chk("stall_wr_cnt", 512'(wr_pulses), 512'(1));
        chk("stall_cmp_cnt", 512'(cmp_pulses), 512'(1));
        L2_miss_stall = 1'b0;
        tick();

        // Same-cycle grant and rvalid: 4 beats, wr_en then L2_complete.
        d0 = 128'h10; d1 = 128'h11; d2 = 128'h12; d3 = 128'h13;
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h0000005;
        tick();
        beat("f0", 28'h0000014, 0, 0, 1, d0);
        beat("f1", 28'h0000015, 0, 0, 1, d1);
        beat("f2", 28'h0000016, 0, 0, 1, d2);
        beat("f3", 28'h0000017, 0, 0, 1, d3);
        chk("fast_wr", 512'(L2_wr_en), 512'(1'b1));
        tick();
        chk("fast_cmp", 512'(L2_complete), 512'(1'b1));
        chk("fast_data", L2_data_wd, {d3, d2, d1, d0});

        // Stall held 4 cycles after completion: no new request.
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req === 1'b1) seen = 1'b1;
        end
        chk("hold_noreq", 512'(seen), 512'(1'b0));
        L2_miss_stall = 1'b0;
        tick();
        chk("hold_idle", 512'(mem_req), 512'(1'b0));
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h0000006;
        tick();
        chk("rerise_req", 512'(mem_req), 512'(1'b1));
        chk("rerise_addr", 512'(mem_beat_addr), 512'(28'h0000018));
        beat("r0", 28'h0000018, 0, 0, 1, d0);
        beat("r1", 28'h0000019, 0, 0, 1, d1);
        beat("r2", 28'h000001A, 0, 0, 1, d2);
        beat("r3", 28'h000001B, 0, 0, 1, d3);
        tick();
        L2_miss_stall = 1'b0;
        tick();
        tick();

        // Write request: error, no memory traffic, completion next cycle.
        chk("pre_err", 512'(refill_err), 512'(1'b0));
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h0000077;
        mem_rw        = WRITE;
        tick();
        chk("wr_noreq", 512'(mem_req), 512'(1'b0));
        chk("wr_err", 512'(refill_err), 512'(1'b1));
        chk("wr_cmp", 512'(L2_complete), 512'(1'b1));
        chk("wr_noen", 512'(L2_wr_en), 512'(1'b0));
        tick();
        chk("wr_cmp_off", 512'(L2_complete), 512'(1'b0));
        chk("wr_err_sticky", 512'(refill_err), 512'(1'b1));
        L2_miss_stall = 1'b0;
        mem_rw        = READ;
        tick();

        // Reset in the middle of beat 2, then restart from beat 0.
        d0 = 128'h20; d1 = 128'h21; d2 = 128'h22; d3 = 128'h23;
        L2_miss_stall = 1'b1;
        mem_addr      = 26'h0000ABC;
        tick();
        beat("x0", 28'h0002AF0, 0, 0, 0, d0);
        beat("x1", 28'h0002AF1, 0, 0, 0, d1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst_req", 512'(mem_req), 512'(1'b0));
        chk("arst_baddr", 512'(mem_beat_addr), 512'(28'h0));
        chk("arst_data", L2_data_wd, 512'h0);
        chk("arst_err", 512'(refill_err), 512'(1'b0));
        chk("arst_cmp", 512'(L2_complete), 512'(1'b0));
        #2 rst = 1'b1;
        tick();
        chk("restart_req", 512'(mem_req), 512'(1'b1));
        chk("restart_addr", 512'(mem_beat_addr), 512'(28'h0002AF0));
        beat("y0", 28'h0002AF0, 0, 0, 1, d0);
        beat("y1", 28'h0002AF1, 0, 0, 1, d1);
        beat("y2", 28'h0002AF2, 0, 0, 1, d2);
        beat("y3", 28'h0002AF3, 0, 0, 1, d3);
        chk("restart_wr", 512'(L2_wr_en), 512'(1'b1));
        chk("restart_data", L2_data_wd, {d3, d2, d1, d0});
        tick();
        chk("restart_cmp", 512'(L2_complete), 512'(1'b1));
        L2_miss_stall = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
